// File: rtl/bus_arb_pkg.sv
// Shared types and limits for the bus grant arbiter slice.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam int unsigned MAX_REQ        = 16;
  localparam int unsigned MAX_TURNAROUND = 15;

endpackage

// File: rtl/bus_grant_arbiter_rr_picker.sv
// Round-robin winner search: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  int unsigned          w_pos;
  int unsigned          w_sum;

  // Doubling req lets a plain right shift act as a rotate.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  always_comb begin
    w_pos = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_rot[NUM_REQ-1-i]) w_pos = NUM_REQ - 1 - i;
    end
    w_sum = w_pos + 32'(ptr);
    if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
    found = |w_rot;
    idx   = PW'(w_sum);
  end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus grant arbiter with max-hold revoke and dead-bus turnaround gap.
module bus_grant_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         enable,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [3:0]    GAP_LIM  = 4'(TURNAROUND);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("bus_grant_arbiter: NUM_REQ must be 2..16");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_grant_arbiter: MAX_HOLD must be 1..255");
  end
  if (TURNAROUND < 1 || TURNAROUND > MAX_TURNAROUND) begin : g_bad_turnaround
    $error("bus_grant_arbiter: TURNAROUND must be 1..15");
  end

  state_t               r_state, w_state_n;
  logic [PW-1:0]        r_ptr, w_ptr_n;
  logic [HW-1:0]        r_hold, w_hold_n;
  logic [3:0]           r_gap, w_gap_n;
  logic [NUM_REQ-1:0]   r_enable, w_enable_n;
  logic [PW-1:0]        r_grant_id, w_grant_id_n;
  logic                 r_timeout, w_timeout_n;
  logic                 w_found;
  logic [PW-1:0]        w_idx;
  logic                 w_at_max;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_at_max = (r_hold == HOLD_LIM);

  always_comb begin
    w_state_n    = r_state;
    w_ptr_n      = r_ptr;
    w_hold_n     = r_hold;
    w_gap_n      = r_gap;
    w_enable_n   = r_enable;
    w_grant_id_n = r_grant_id;
    w_timeout_n  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_n    = GRANT;
          w_enable_n   = NUM_REQ'(1) << w_idx;
          w_grant_id_n = w_idx;
          w_hold_n     = HW'(1);
        end
      end
      GRANT: begin
        // Hitting MAX_HOLD wins over a same-cycle release so timeout still fires.
        if (w_at_max || !req[r_grant_id]) begin
          w_state_n   = GAP;
          w_enable_n  = '0;
          w_ptr_n     = (r_grant_id == LAST_IDX) ? '0 : r_grant_id + PW'(1);
          w_gap_n     = 4'd1;
          w_timeout_n = w_at_max;
        end else begin
          w_hold_n = r_hold + HW'(1);
        end
      end
      GAP: begin
        if (r_gap < GAP_LIM) begin
          w_gap_n = r_gap + 4'd1;
        end else if (w_found) begin
          w_state_n    = GRANT;
          w_enable_n   = NUM_REQ'(1) << w_idx;
          w_grant_id_n = w_idx;
          w_hold_n     = HW'(1);
        end else begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold     <= '0;
      r_gap      <= '0;
      r_enable   <= '0;
      r_grant_id <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_ptr      <= w_ptr_n;
      r_hold     <= w_hold_n;
      r_gap      <= w_gap_n;
      r_enable   <= w_enable_n;
      r_grant_id <= w_grant_id_n;
      r_timeout  <= w_timeout_n;
    end
  end

  assign enable   = r_enable;
  assign grant_id = r_grant_id;
  assign busy     = |r_enable;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Self-checking bench: three arbiter configurations against a behavioural grant model.
module tb_bus_grant_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] req0, req1, req2;
  logic [3:0] en0, en1, en2;
  logic [1:0] gid0, gid1, gid2;
  logic       busy0, busy1, busy2;
  logic       to0, to1, to2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(16), .TURNAROUND(1)) u0 (
    .clk(clk), .reset(rst), .req(req0), .enable(en0), .grant_id(gid0), .busy(busy0), .timeout(to0));
  bus_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(4), .TURNAROUND(1)) u1 (
    .clk(clk), .reset(rst), .req(req1), .enable(en1), .grant_id(gid1), .busy(busy1), .timeout(to1));
  bus_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(2), .TURNAROUND(3)) u2 (
    .clk(clk), .reset(rst), .req(req2), .enable(en2), .grant_id(gid2), .busy(busy2), .timeout(to2));

  // Model: who owns the bus, how long, how many dead cycles remain, where the search starts.
  typedef struct {
    int owner;
    int hold;
    int gap_left;
    int ptr;
    int last;
    bit to;
  } mst_t;

  mst_t m[3];

  function automatic mst_t mreset();
    mst_t s;
    s.owner = -1; s.hold = 0; s.gap_left = 0; s.ptr = 0; s.last = 0; s.to = 1'b0;
    return s;
  endfunction

  function automatic mst_t mstep(mst_t s, logic [3:0] r, int maxh, int ta);
    mst_t n = s;
    n.to = 1'b0;
    if (s.owner >= 0) begin
      if (s.hold == maxh || !r[s.owner]) begin
        n.to       = (s.hold == maxh);
        n.ptr      = (s.owner + 1) % 4;
        n.owner    = -1;
        n.hold     = 0;
        n.gap_left = ta;
      end else begin
        n.hold = s.hold + 1;
      end
    end else if (s.gap_left > 1) begin
      n.gap_left = s.gap_left - 1;
    end else begin
      n.gap_left = 0;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (s.ptr + k) % 4;
        if (n.owner < 0 && r[j]) begin
          n.owner = j;
          n.last  = j;
          n.hold  = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] men(mst_t s);
    logic [3:0] e;
    e = '0;
    if (s.owner >= 0) e[s.owner] = 1'b1;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) m[i] <= mreset();
    end else begin
      m[0] <= mstep(m[0], req0, 16, 1);
      m[1] <= mstep(m[1], req1, 4, 1);
      m[2] <= mstep(m[2], req2, 2, 3);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input mst_t s, input logic [3:0] en, input logic [1:0] gid,
                          input logic b, input logic t);
    logic [3:0] e;
    e = men(s);
    chk($sformatf("u%0d.enable", k), 32'(en), 32'(e));
    chk($sformatf("u%0d.grant_id", k), 32'(gid), 32'(s.last));
    chk($sformatf("u%0d.timeout", k), 32'(t), 32'(s.to));
    chk($sformatf("u%0d.busy", k), 32'(b), 32'(|e));
    chk($sformatf("u%0d.busy_vs_enable", k), 32'(b), 32'(|en));
    chk($sformatf("u%0d.onehot0", k), 32'($onehot0(en)), 32'(1));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, m[0], en0, gid0, busy0, to0);
    cmp_inst(1, m[1], en1, gid1, busy1, to1);
    cmp_inst(2, m[2], en2, gid2, busy2, to2);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    rst  = 1'b1;
    req0 = 4'hF; req1 = 4'hF; req2 = 4'hF;

    // Reset held with every source requesting
    tick(3);
    chk("t1.enable", 32'(en0), 32'(0));
    chk("t1.grant_id", 32'(gid0), 32'(0));
    chk("t1.busy", 32'(busy0), 32'(0));
    chk("t1.timeout", 32'(to0), 32'(0));
    chk("t1.enable_u1", 32'(en1), 32'(0));
    chk("t1.enable_u2", 32'(en2), 32'(0));
    req0 = '0; req1 = '0; req2 = '0;
    rst  = 1'b0;
    tick(2);

    // Single requester, released after five cycles
    req0 = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      chk($sformatf("t2.enable_c%0d", c), 32'(en0), 32'(4'b0100));
      if (c == 1) chk("t2.grant_id", 32'(gid0), 32'(2));
      if (c == 5) req0 = '0;
    end
    tick(1);
    chk("t2.enable_c6", 32'(en0), 32'(0));
    chk("t2.no_timeout", 32'(to0), 32'(0));
    tick(2);

    // Reset mid-grant: enable drops asynchronously, search restarts at 0
    req0 = 4'b1100;
    tick(1);
    chk("t5.first_winner", 32'(en0), 32'(4'b1000));
    tick(2);
    #1 rst = 1'b1;
    #1;
    chk("t5.async_drop", 32'(en0), 32'(0));
    chk("t5.async_busy", 32'(busy0), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1);
    chk("t5.regrant", 32'(en0), 32'(4'b0100));
    chk("t5.regrant_id", 32'(gid0), 32'(2));
    req0 = '0;
    tick(3);

    // Release of source 1 moves the search past it
    req0 = 4'b0010;
    tick(1);
    chk("t4.grant1", 32'(en0), 32'(4'b0010));
    tick(1);
    req0 = 4'b1000;
    tick(1);
    chk("t4.gap", 32'(en0), 32'(0));
    req0 = 4'b1010;
    tick(1);
    chk("t4.next_is_3", 32'(en0), 32'(4'b1000));
    chk("t4.next_id", 32'(gid0), 32'(3));
    req0 = '0;
    tick(3);

    // All requesting with MAX_HOLD=4: 4 granted cycles, 1 dead cycle, rotate
    req1 = 4'hF;
    for (int c = 1; c <= 24; c++) begin
      tick(1);
      e = '0;
      if (c % 5 != 0) e[((c - 1) / 5) % 4] = 1'b1;
      chk($sformatf("t3.enable_c%0d", c), 32'(en1), 32'(e));
      chk($sformatf("t3.timeout_c%0d", c), 32'(to1), 32'(c % 5 == 0));
    end
    req1 = '0;
    tick(8);

    // TURNAROUND=3, MAX_HOLD=2: 2 granted cycles, 3 dead cycles
    req2 = 4'b0011;
    for (int c = 1; c <= 15; c++) begin
      tick(1);
      e = '0;
      if (c % 5 == 1 || c % 5 == 2) e[((c - 1) / 5) % 2] = 1'b1;
      chk($sformatf("t6.enable_c%0d", c), 32'(en2), 32'(e));
      chk($sformatf("t6.timeout_c%0d", c), 32'(to2), 32'(c % 5 == 3));
    end
    req2 = '0;
    tick(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
